output_drain_transposer: RTL and testbench

Downstream consumer of the output buffer's read port. It fetches 16-wide column vectors of a tile (1-cycle synchronous read latency) and transposes each WxW tile in a register bank. It then streams the tile out row by row over a valid/ready interface to the AXI write master FSM. One invocation drains `tile_count` consecutive tiles starting at `base_addr`.

---
 rtl/output_drain_transposer.sv | 197 +++++++++++++++++++
 tb/tb_output_drain_transposer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_transposer.sv
// Output drain transposer: reads WxW tiles column by column and streams them out row by row.
// Optional macro OUTPUT_DRAIN_PERF_EN adds the stall_cycles back-pressure counter output.
module output_drain_transposer #(
    parameter int DATA_WIDTH           = 32,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int ADDR_WIDTH           = 10
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [ADDR_WIDTH-1:0]                          base_addr,
    input  logic [ADDR_WIDTH-1:0]                          tile_count,
    output logic                                           busy,
    output logic                                           done,
    output logic [ADDR_WIDTH-1:0]                          rd_addr,
    output logic                                           rd_en,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] rd_data,
    output logic                                           m_valid,
    input  logic                                           m_ready,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] m_data,
    output logic                                           m_last
`ifdef OUTPUT_DRAIN_PERF_EN
    ,
    output logic [31:0]                                    stall_cycles
`endif
);

    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_TILE = ADDR_WIDTH'(W);
    localparam logic [CW-1:0]         C_LAST = CW'(W - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] tile_base_q, tile_base_d;
    logic [ADDR_WIDTH-1:0] tile_idx_q, tile_idx_d;
    logic [ADDR_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  cap_en_q, cap_en_d;
    logic [CW-1:0]         cap_col_q, cap_col_d;
    logic                  m_valid_q, m_valid_d;
    logic                  done_q, done_d;

    logic [W-1:0][W-1:0][DATA_WIDTH-1:0] bank_q;

    logic last_tile;
    logic handshake;

    assign last_tile = (tile_idx_q == tile_cnt_q - A_ONE);
    assign handshake = m_valid_q && m_ready;

    // Next-state logic for the load/drain sequencer.
    always_comb begin
        state_d     = state_q;
        tile_base_d = tile_base_q;
        tile_idx_d  = tile_idx_q;
        tile_cnt_d  = tile_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        cap_en_d    = rd_en_q;
        cap_col_d   = col_q;
        m_valid_d   = m_valid_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tile_base_d = base_addr;
                    tile_cnt_d  = tile_count;
                    tile_idx_d  = '0;
                    col_d       = '0;
                    row_d       = '0;
                    if (tile_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_LOAD;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr;
                    end
                end
            end
            S_LOAD: begin
                if (rd_en_q) begin
                    if (col_q == C_LAST) begin
                        rd_en_d = 1'b0;
                    end else begin
                        col_d     = col_q + 1'b1;
                        rd_addr_d = rd_addr_q + A_ONE;
                    end
                end
                // The last column lands one cycle after its read.
                if (cap_en_q && cap_col_q == C_LAST) begin
                    state_d   = S_DRAIN;
                    m_valid_d = 1'b1;
                    row_d     = '0;
                end
            end
            S_DRAIN: begin
                if (handshake) begin
                    if (row_q == C_LAST) begin
                        m_valid_d = 1'b0;
                        if (last_tile) begin
                            state_d = S_DONE;
                        end else begin
                            tile_idx_d  = tile_idx_q + A_ONE;
                            tile_base_d = tile_base_q + A_TILE;
                            rd_addr_d   = tile_base_q + A_TILE;
                            col_d       = '0;
                            rd_en_d     = 1'b1;
                            state_d     = S_LOAD;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tile_base_q <= '0;
            tile_idx_q  <= '0;
            tile_cnt_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            cap_en_q    <= 1'b0;
            cap_col_q   <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_base_q <= tile_base_d;
            tile_idx_q  <= tile_idx_d;
            tile_cnt_q  <= tile_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            cap_en_q    <= cap_en_d;
            cap_col_q   <= cap_col_d;
            m_valid_q   <= m_valid_d;
            done_q      <= done_d;
        end
    end

    // Transpose: each returned column vector lands in one bank column.
    always_ff @(posedge clk) begin
        if (cap_en_q) begin
            for (int r = 0; r < W; r++) begin
                bank_q[r][cap_col_q] <= rd_data[r];
            end
        end
    end

`ifdef OUTPUT_DRAIN_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a beat is offered but not taken.
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && start)) begin
            stall_q <= '0;
        end else if (m_valid_q && !m_ready && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_valid_q ? bank_q[row_q] : '0;
    assign m_last  = m_valid_q && (row_q == C_LAST) && last_tile;

endmodule

// File: tb/tb_output_drain_transposer.sv
// Bench for output_drain_transposer: buffer model, vector table and reset-abort sequence.
// Build with OUTPUT_DRAIN_PERF_EN defined to also check stall_cycles.
module tb_output_drain_transposer;

    localparam int DW = 32;
    localparam int W  = 16;
    localparam int AW = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW-1:0]        tile_count;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        rd_addr;
    logic                 rd_en;
    logic [W-1:0][DW-1:0] rd_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [W-1:0][DW-1:0] m_data;
    logic                 m_last;
`ifdef OUTPUT_DRAIN_PERF_EN
    logic [31:0]          stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0][DW-1:0] mem [1024];

    always #5 clk = ~clk;

    output_drain_transposer #(
        .DATA_WIDTH(DW),
        .SYSTOLIC_ARRAY_WIDTH(W),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .tile_count(tile_count),
        .busy(busy),
        .done(done),
        .rd_addr(rd_addr),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last)
`ifdef OUTPUT_DRAIN_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Output buffer model with one cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] cnt;
        bit            tog;
        bit            restart;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [W*DW-1:0] act,
                        input logic [W*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int reads = 0;
        int beats = 0;
        int first_rd = -1;
        int first_v = -1;
        int done_cyc = -1;
        int dones = 0;
        int last_acc = -1;
        int stalls = 0;
        int nb;
        bit held = 1'b0;
        bit prev_stall = 1'b0;
        logic [W-1:0][DW-1:0] ex;
        logic [AW-1:0] a;
        int t;
        int r;
        nb = 16 * int'(v.cnt);
        base_addr  = v.base;
        tile_count = v.cnt;
        m_ready    = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 2000; cyc++) begin
            if (cyc == 1) chk("busy_up", busy, 1);
            if (v.restart) begin
                start = (cyc == 5);
                base_addr = (cyc == 5) ? 10'd500 : v.base;
            end
            if (prev_stall) chk("valid_hold", m_valid, 1);
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                a = v.base + AW'(reads);
                chk("rd_addr", rd_addr, a);
                chk("rd_in_drain", m_valid, 0);
                reads++;
            end
            prev_stall = 1'b0;
            if (m_valid) begin
                if (first_v < 0) first_v = cyc;
                t = beats / 16;
                r = beats % 16;
                for (int c = 0; c < W; c++) begin
                    a = v.base + AW'(16 * t + c);
                    ex[c] = 100 * int'(a) + r;
                end
                chkv("m_data", m_data, ex);
                chk("m_last", m_last, beats == nb - 1);
                m_ready = !(v.tog && beats[0] && !held);
                if (m_ready) begin
                    beats++;
                    last_acc = cyc;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    stalls++;
                    prev_stall = 1'b1;
                end
            end else begin
                m_ready = 1'b1;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        m_ready = 1'b1;
        chk("beats", beats, nb);
        chk("reads", reads, nb);
        chk("done_count", dones, 1);
        chk("busy_end", busy, 0);
        if (v.cnt != 0) begin
            chk("first_rd", first_rd, 1);
            chk("first_valid", first_v, 18);
            chk("done_lat", (done_cyc - last_acc) inside {1, 2}, 1);
        end else begin
            chk("done_t2", done_cyc, 2);
        end
`ifdef OUTPUT_DRAIN_PERF_EN
        chk("stall_cycles", stall_cycles, stalls);
        if (v.tog && v.cnt == 2) chk("stall16", stalls, 16);
`endif
    endtask

    vec_t vt [6];

    initial begin
        int acc;
        bit hit;
        for (int a = 0; a < 1024; a++)
            for (int r = 0; r < W; r++)
                mem[a][r] = 100 * a + r;

        vt[0] = '{base: 10'd0,    cnt: 10'd1, tog: 1'b0, restart: 1'b0};
        vt[1] = '{base: 10'd1020, cnt: 10'd1, tog: 1'b0, restart: 1'b0};
        vt[2] = '{base: 10'd32,   cnt: 10'd2, tog: 1'b1, restart: 1'b0};
        vt[3] = '{base: 10'd0,    cnt: 10'd0, tog: 1'b0, restart: 1'b0};
        vt[4] = '{base: 10'd64,   cnt: 10'd1, tog: 1'b0, restart: 1'b1};
        vt[5] = '{base: 10'd1008, cnt: 10'd2, tog: 1'b1, restart: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        tile_count = '0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chkv("rst_m_data", m_data, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run(vt[i]);
            @(negedge clk);
        end

        // Abort during DRAIN with row 5 stalled.
        base_addr = 10'd0;
        tile_count = 10'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (m_valid) begin
                if (acc < 5) begin
                    m_ready = 1'b1;
                    acc++;
                end else begin
                    m_ready = 1'b0;
                    hit = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        chk("abort_reached", hit, 1);
        @(negedge clk);
        chk("abort_stalled", m_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_done", done, 0);
        chk("abort_m_last", m_last, 0);
        chkv("abort_m_data", m_data, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_quiet", {rd_en, m_valid, busy}, 3'b000);
        end
        run(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
